// File: rtl/shared_div_pkg.sv
// Shared definitions for the multi-client restoring divider: FSM encoding and
// default sizing.
package shared_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 26;
  localparam int DEF_N_CH  = 2;

endpackage

// File: rtl/shared_divider_rr_arbiter.sv
// Combinational round-robin pick: the first requesting channel found after
// last_served, wrapping around, wins.
module rr_arbiter
  import shared_div_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int IW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   last_served,
  output logic [IW-1:0]   grant,
  output logic            valid
);

  int          idx;
  logic [IW-1:0] idx_sel;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant   = '0;
    valid   = 1'b0;
    idx     = 0;
    idx_sel = '0;
    for (int off = N_CH; off >= 1; off--) begin
      idx     = (int'(last_served) + off) % N_CH;
      idx_sel = IW'(idx);
      if (req[idx_sel]) begin
        grant = idx_sel;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_divider.sv
// One restoring divider time-shared between N_CH clients; a request is
// granted round-robin and finishes WIDTH+1 enabled cycles later.
module shared_divider
  import shared_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_CH  = DEF_N_CH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH*WIDTH-1:0]   dividend,
  input  logic [N_CH*WIDTH-1:0]   divisor,
  output logic [WIDTH-1:0]        quotient,
  output logic [WIDTH-1:0]        remainder,
  output logic                    done,
  output logic [N_CH-1:0]         done_ch,
  output logic                    busy,
  output logic                    div_zero
);

  localparam int IW = $clog2(N_CH);
  localparam int CW = $clog2(WIDTH + 1);

  state_t            state_reg, state_next;
  logic [IW-1:0]     ch_reg, last_served_reg, grant;
  logic              grant_valid;
  logic [CW-1:0]     cnt_reg;
  logic [WIDTH-1:0]  dvd_reg, dvs_reg;
  logic [WIDTH:0]    rem_reg;
  logic [WIDTH-1:0]  quotient_reg, remainder_reg;
  logic              div_zero_reg;

  logic              last_step, q_bit;
  logic [WIDTH:0]    shifted, rem_step;
  logic [WIDTH-1:0]  dvd_step;

  rr_arbiter #(.N_CH(N_CH), .IW(IW)) u_arb (
    .req         (req),
    .last_served (last_served_reg),
    .grant       (grant),
    .valid       (grant_valid)
  );

  // dvd_reg shifts the dividend out at the top and collects quotient bits at
  // the bottom; after WIDTH steps it holds the quotient.
  always_comb begin
    shifted   = {rem_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};
    q_bit     = (shifted >= {1'b0, dvs_reg});
    rem_step  = q_bit ? (shifted - {1'b0, dvs_reg}) : shifted;
    dvd_step  = {dvd_reg[WIDTH-2:0], q_bit};
    last_step = (cnt_reg == CW'(WIDTH - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else if (en) state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = RUN;
      RUN:     if (last_step)   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_reg != IDLE);
    done    = (state_reg == DONE) && en;
    done_ch = '0;
    if (done) done_ch[ch_reg] = 1'b1;
  end

  // Results are captured on the final step so they are already stable
  // during the done cycle and then held until the next completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ch_reg          <= '0;
      last_served_reg <= IW'(N_CH - 1);
      cnt_reg         <= '0;
      dvd_reg         <= '0;
      dvs_reg         <= '0;
      rem_reg         <= '0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      div_zero_reg    <= 1'b0;
    end else if (en) begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            ch_reg  <= grant;
            dvd_reg <= dividend[grant*WIDTH +: WIDTH];
            dvs_reg <= divisor[grant*WIDTH +: WIDTH];
            rem_reg <= '0;
            cnt_reg <= '0;
          end
        end
        RUN: begin
          dvd_reg <= dvd_step;
          rem_reg <= rem_step;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_step) begin
            quotient_reg  <= dvd_step;
            remainder_reg <= rem_step[WIDTH-1:0];
            div_zero_reg  <= (dvs_reg == '0);
          end
        end
        DONE: last_served_reg <= ch_reg;
        default: ;
      endcase
    end
  end

  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_shared_divider.sv
// Directed bench for shared_divider: table of single-client divisions with
// optional enable stalls, then arbitration and mid-operation reset sequences.
module tb_shared_divider;

  localparam int W = 26;
  localparam int N = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic           en;
  logic [N-1:0]   req;
  logic [N*W-1:0] dividend, divisor;
  logic [W-1:0]   quotient, remainder;
  logic           done, busy, div_zero;
  logic [N-1:0]   done_ch;

  int checks = 0;
  int errors = 0;

  shared_divider #(.WIDTH(W), .N_CH(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .req       (req),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .done_ch   (done_ch),
    .busy      (busy),
    .div_zero  (div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         ch;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       dz;
    int         lo_start;
    int         lo_len;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for done; en is dropped for cycles lo_start+1 .. lo_start+lo_len
  // counted from the cycle the request is first sampled.
  task automatic wait_done(input int lo_start, input int lo_len, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (!en) chk("no_done_while_en_low", done, 0);
      if (done) begin
        lat = n;
        break;
      end
      en = !((n + 1) > lo_start && (n + 1) <= lo_start + lo_len);
    end
    en = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_done_ch"}, done_ch, 0);
    chk({tag, "_quotient"}, quotient, 0);
    chk({tag, "_remainder"}, remainder, 0);
    chk({tag, "_div_zero"}, div_zero, 0);
  endtask

  initial begin
    int lat;
    vecs[0] = '{0, 26'd1000,      26'd7,         26'd142,       26'd6,         1'b0, 0,  0, 27};
    vecs[1] = '{1, 26'd55,        26'd0,         26'h3FFFFFF,   26'd55,        1'b1, 0,  0, 27};
    vecs[2] = '{0, 26'h3FFFFFF,   26'd1,         26'h3FFFFFF,   26'd0,         1'b0, 0,  0, 27};
    vecs[3] = '{1, 26'd12345,     26'd12345,     26'd1,         26'd0,         1'b0, 0,  0, 27};
    vecs[4] = '{0, 26'd5,         26'd9,         26'd0,         26'd5,         1'b0, 0,  0, 27};
    vecs[5] = '{1, 26'h3FFFFFF,   26'h2000000,   26'd1,         26'h1FFFFFF,   1'b0, 0,  0, 27};
    vecs[6] = '{0, 26'd100000,    26'd256,       26'd390,       26'd160,       1'b0, 0,  0, 27};
    vecs[7] = '{1, 26'd0,         26'd3,         26'd0,         26'd0,         1'b0, 0,  0, 27};
    vecs[8] = '{0, 26'd1000,      26'd7,         26'd142,       26'd6,         1'b0, 10, 5, 32};
    vecs[9] = '{1, 26'd4000,      26'd9,         26'd444,       26'd4,         1'b0, 26, 2, 29};

    reset    = 1'b1;
    en       = 1'b1;
    req      = '0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_cleared("in_reset");
    reset = 1'b0;
    @(negedge clock);
    check_cleared("after_reset");

    foreach (vecs[i]) begin
      dividend[vecs[i].ch*W +: W] = vecs[i].dvd;
      divisor[vecs[i].ch*W +: W]  = vecs[i].dvs;
      req[vecs[i].ch]             = 1'b1;
      wait_done(vecs[i].lo_start, vecs[i].lo_len, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      chk($sformatf("v%0d_div_zero", i), div_zero, vecs[i].dz);
      chk($sformatf("v%0d_done_ch", i), done_ch, 32'd1 << vecs[i].ch);
      $display("vec %0d: ch%0d %0d / %0d -> q=%0d r=%0d dz=%0b lat=%0d",
               i, vecs[i].ch, vecs[i].dvd, vecs[i].dvs, quotient, remainder, div_zero, lat);
      req[vecs[i].ch] = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("v%0d_done_pulse_ends", i), done, 0);
      chk($sformatf("v%0d_idle_after", i), busy, 0);
    end

    // Two clients held continuously: grants must alternate starting at ch0.
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    dividend = {26'd55, 26'd1000};
    divisor  = {26'd0,  26'd7};
    req      = 2'b11;
    for (int j = 0; j < 3; j++) begin
      wait_done(0, 0, lat);
      chk($sformatf("alt%0d_latency", j), lat, (j == 0) ? 27 : 28);
      chk($sformatf("alt%0d_done_ch", j), done_ch, (j % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("alt%0d_quotient", j), quotient, (j % 2 == 0) ? 26'd142 : 26'h3FFFFFF);
      chk($sformatf("alt%0d_div_zero", j), div_zero, (j % 2 == 0) ? 0 : 1);
      $display("alt %0d: done_ch=%b q=%0d r=%0d lat=%0d", j, done_ch, quotient, remainder, lat);
    end

    // ch1 is now mid-operation; reset must abandon it and restart at ch0.
    repeat (10) begin
      @(posedge clock);
      @(negedge clock);
    end
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_cleared("mid_run_reset");
    @(posedge clock);
    @(negedge clock);
    check_cleared("mid_run_reset_hold");
    reset = 1'b0;
    wait_done(0, 0, lat);
    chk("post_reset_latency", lat, 27);
    chk("post_reset_done_ch", done_ch, 2'b01);
    chk("post_reset_quotient", quotient, 142);
    chk("post_reset_remainder", remainder, 6);
    $display("post-reset: done_ch=%b q=%0d r=%0d lat=%0d", done_ch, quotient, remainder, lat);
    req = '0;
    @(posedge clock);
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
